// File: rtl/pixel_fb_writer.sv
// Generic FWFT FIFO: head_dat always shows the oldest entry.
// Latency: a push is visible at head_dat the cycle after it lands in an empty FIFO.
// Backpressure: the caller must not push when full or pop when empty.
module fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push_vld,
  input  logic [W-1:0] push_dat,
  input  logic         pop_vld,
  output logic [W-1:0] head_dat,
  output logic         empty,
  output logic         full
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  ram [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0]   count;

  assign head_dat = ram[rd_ptr];
  assign empty    = (count == '0);
  assign full     = (count == (AW+1)'(DEPTH));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_vld) wr_ptr <= wr_ptr + AW'(1);
      if (pop_vld)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + {{AW{1'b0}}, push_vld} - {{AW{1'b0}}, pop_vld};
    end
  end

  always_ff @(posedge clk) begin
    if (push_vld) ram[wr_ptr] <= push_dat;
  end
endmodule

// Framebuffer writer: centred plot coords -> clipped screen addresses -> buffered memory writes; clear sweep.
// Latency: accepted on-screen pixel reaches mem_* one cycle later when the buffer is empty.
// Backpressure: pix_ready low when buffer full, clear pending or sweeping; mem_* held while !mem_ready.
module pixel_fb_writer #(
  parameter int WIDTH      = 320,
  parameter int HEIGHT     = 240,
  parameter int X_ORIGIN   = 160,
  parameter int Y_ORIGIN   = 120,
  parameter int ADDR_W     = 17,
  parameter int COLOR_W    = 8,
  parameter int BG_COLOR   = 0,
  parameter int FIFO_DEPTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pix_valid,
  output logic               pix_ready,
  input  logic [8:0]         x_in,
  input  logic [7:0]         y_in,
  input  logic [COLOR_W-1:0] color,
  input  logic               src_done,
  input  logic               clear_req,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [COLOR_W-1:0] mem_data,
  input  logic               mem_ready,
  output logic               busy,
  output logic [15:0]        clipped_cnt,
  output logic               frame_done
);
  localparam int NPIX = WIDTH * HEIGHT;

  typedef struct packed {
    logic [ADDR_W-1:0]  addr;
    logic [COLOR_W-1:0] data;
  } fb_entry_t;

  typedef enum logic {DRAW, CLEAR} state_t;

  state_t            state, state_nxt;
  logic              clear_pend, clear_pend_nxt;
  logic              done_pend, done_pend_nxt;
  logic              src_done_q;
  logic [ADDR_W-1:0] cnt, cnt_nxt;
  logic [15:0]       clip_nxt;

  logic              fifo_empty, fifo_full, push, pop;
  fb_entry_t         head, entry;
  logic signed [10:0] sx, sy;
  logic              on_screen;

  // Screen y grows downward, math y grows upward.
  assign sx = $signed({{2{x_in[8]}}, x_in}) + $signed(11'(X_ORIGIN));
  assign sy = $signed(11'(Y_ORIGIN)) - $signed({{3{y_in[7]}}, y_in});
  assign on_screen = (sx >= 11'sd0) && (sx < $signed(11'(WIDTH))) &&
                     (sy >= 11'sd0) && (sy < $signed(11'(HEIGHT)));
  assign entry.addr = ADDR_W'(sy[9:0]) * ADDR_W'(WIDTH) + ADDR_W'(sx[9:0]);
  assign entry.data = color;

  fifo #(.W($bits(fb_entry_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push_vld (push),
    .push_dat (entry),
    .pop_vld  (pop),
    .head_dat (head),
    .empty    (fifo_empty),
    .full     (fifo_full)
  );

  assign busy = (state == CLEAR) || !fifo_empty || clear_pend;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= DRAW;
      clear_pend  <= 1'b0;
      done_pend   <= 1'b0;
      src_done_q  <= 1'b0;
      cnt         <= '0;
      clipped_cnt <= '0;
    end else begin
      state       <= state_nxt;
      clear_pend  <= clear_pend_nxt;
      done_pend   <= done_pend_nxt;
      src_done_q  <= src_done;
      cnt         <= cnt_nxt;
      clipped_cnt <= clip_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    clear_pend_nxt = clear_pend;
    done_pend_nxt  = done_pend;
    cnt_nxt        = cnt;
    clip_nxt       = clipped_cnt;
    pix_ready      = 1'b0;
    mem_we         = 1'b0;
    mem_addr       = '0;
    mem_data       = '0;
    push           = 1'b0;
    pop            = 1'b0;
    frame_done     = 1'b0;
    case (state)
      DRAW: begin
        pix_ready = !fifo_full && !clear_pend;
        mem_we    = !fifo_empty;
        if (!fifo_empty) begin
          mem_addr = head.addr;
          mem_data = head.data;
        end
        pop = !fifo_empty && mem_ready;
        if (pix_valid && pix_ready) begin
          if (on_screen) push = 1'b1;
          else if (clipped_cnt != 16'hFFFF) clip_nxt = clipped_cnt + 16'd1;
        end
        if (clear_req) clear_pend_nxt = 1'b1;
        // Sweep starts only after every buffered pixel has been written.
        if (clear_pend && fifo_empty) begin
          state_nxt = CLEAR;
          cnt_nxt   = '0;
        end
        frame_done = done_pend && fifo_empty && !clear_pend;
      end
      CLEAR: begin
        mem_we   = 1'b1;
        mem_addr = cnt;
        mem_data = COLOR_W'(BG_COLOR);
        if (mem_ready) begin
          cnt_nxt = cnt + ADDR_W'(1);
          if (cnt == ADDR_W'(NPIX - 1)) begin
            state_nxt      = DRAW;
            clear_pend_nxt = 1'b0;
          end
        end
      end
      default: state_nxt = DRAW;
    endcase
    if (src_done && !src_done_q) done_pend_nxt = 1'b1;
    else if (frame_done)         done_pend_nxt = 1'b0;
  end
endmodule
